// File: rtl/axi_stream_rr_arbiter_if.sv
// Bundle of the N:1 stream arbiter: NUM_PORTS packed slave lanes plus one master lane.
// Latency: none (wiring only).
// Backpressure: slave modport is the arbiter side; master modport is the frame source/sink side.
interface axi_stream_rr_arbiter_if #(
  parameter int NUM_PORTS   = 4,
  parameter int TDATA_WIDTH = 64,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int IDX_WIDTH   = $clog2(NUM_PORTS)
);
  localparam int TKEEP_WIDTH = TDATA_WIDTH / 8;

  // slave lanes, port i occupies slice [i*W +: W] of each packed vector
  logic [NUM_PORTS-1:0]             s_tvalid;
  logic [NUM_PORTS-1:0]             s_tready;
  logic [NUM_PORTS*TDATA_WIDTH-1:0] s_tdata;
  logic [NUM_PORTS*TKEEP_WIDTH-1:0] s_tkeep;
  logic [NUM_PORTS-1:0]             s_tlast;
  logic [NUM_PORTS*TDEST_WIDTH-1:0] s_tdest;
  logic [NUM_PORTS*TUSER_WIDTH-1:0] s_tuser;

  // merged master lane
  logic                   m_tvalid;
  logic                   m_tready;
  logic [TDATA_WIDTH-1:0] m_tdata;
  logic [TKEEP_WIDTH-1:0] m_tkeep;
  logic                   m_tlast;
  logic [TDEST_WIDTH-1:0] m_tdest;
  logic [TUSER_WIDTH-1:0] m_tuser;
  logic [IDX_WIDTH-1:0]   m_tid;

  // arbitration status
  logic [NUM_PORTS-1:0]   grant;
  logic                   busy;

  // arbiter side
  modport slave (
    input  s_tvalid, s_tdata, s_tkeep, s_tlast, s_tdest, s_tuser, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tdest, m_tuser, m_tid,
    output grant, busy
  );

  // environment side: drives the sources and the downstream ready
  modport master (
    output s_tvalid, s_tdata, s_tkeep, s_tlast, s_tdest, s_tuser, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tdest, m_tuser, m_tid,
    input  grant, busy
  );
endinterface

// File: rtl/axi_stream_rr_arbiter.sv
// Packet-atomic N:1 AXI4-Stream arbiter, grant held from first beat to tlast; AXIS_ARB_STRICT_PRIO_EN selects fixed priority.
// Latency: 1 cycle arbitration in IDLE, then accept at t -> m_tvalid at t+1 through one output register.
// Backpressure: granted s_tready = ~m_tvalid | m_tready (registered-only terms), all other s_tready low.
module axi_stream_rr_arbiter #(
  parameter int NUM_PORTS   = 4,
  parameter int TDATA_WIDTH = 64,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int IDX_WIDTH   = $clog2(NUM_PORTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_stream_rr_arbiter_if.slave bus
);

  localparam int                   TKEEP_WIDTH = TDATA_WIDTH / 8;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX    = IDX_WIDTH'(NUM_PORTS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [IDX_WIDTH-1:0] gnt_idx;
  logic [IDX_WIDTH-1:0] gnt_idx_nxt;
  logic [IDX_WIDTH-1:0] rr_ptr;       // last served port
  logic [IDX_WIDTH-1:0] rr_ptr_nxt;

  // winner of the current request vector
  logic [IDX_WIDTH-1:0] cand;
  logic [IDX_WIDTH-1:0] win_idx;
  logic                 win_vld;

  // handshake with the granted source
  logic [NUM_PORTS-1:0] ready;
  logic                 load;

  // output register
  logic                   out_valid;
  logic [TDATA_WIDTH-1:0] out_data;
  logic [TKEEP_WIDTH-1:0] out_keep;
  logic                   out_last;
  logic [TDEST_WIDTH-1:0] out_dest;
  logic [TUSER_WIDTH-1:0] out_user;
  logic [IDX_WIDTH-1:0]   out_id;

  logic [NUM_PORTS-1:0]   grant_vec;

  // pick the next port to serve from the raw request vector
  always_comb begin
    cand    = '0;
    win_idx = '0;
    win_vld = 1'b0;
`ifdef AXIS_ARB_STRICT_PRIO_EN
    // fixed priority: the lowest requesting index wins
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = IDX_WIDTH'(i);
      if (!win_vld && bus.s_tvalid[cand]) begin
        win_idx = cand;
        win_vld = 1'b1;
      end
    end
`else
    // round robin: scan rr_ptr+1, rr_ptr+2, ... wrapping at NUM_PORTS
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = IDX_WIDTH'((int'(rr_ptr) + k) % NUM_PORTS);
      if (!win_vld && bus.s_tvalid[cand]) begin
        win_idx = cand;
        win_vld = 1'b1;
      end
    end
`endif
  end

  // FSM state, grant index and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt_idx <= '0;
      rr_ptr  <= LAST_IDX;
    end else begin
      state   <= state_nxt;
      gnt_idx <= gnt_idx_nxt;
      rr_ptr  <= rr_ptr_nxt;
    end
  end

  // next state, per-port ready and beat acceptance
  always_comb begin
    state_nxt   = state;
    gnt_idx_nxt = gnt_idx;
    rr_ptr_nxt  = rr_ptr;
    ready       = '0;
    load        = 1'b0;
    case (state)
      IDLE: begin
        // no source is ready here, so the first beat is always taken in PASS
        if (win_vld) begin
          gnt_idx_nxt = win_idx;
          state_nxt   = PASS;
        end
      end
      PASS: begin
        // ready uses only registered state and m_tready, never s_tvalid
        ready[gnt_idx] = ~out_valid | bus.m_tready;
        load           = bus.s_tvalid[gnt_idx] & ready[gnt_idx];
        if (load && bus.s_tlast[gnt_idx]) begin
          state_nxt = IDLE;
`ifndef AXIS_ARB_STRICT_PRIO_EN
          rr_ptr_nxt = gnt_idx;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // output pipeline stage: load on accept, drain on m_tready regardless of FSM state
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_dest  <= '0;
      out_user  <= '0;
      out_id    <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= bus.s_tdata[gnt_idx*TDATA_WIDTH +: TDATA_WIDTH];
      out_keep  <= bus.s_tkeep[gnt_idx*TKEEP_WIDTH +: TKEEP_WIDTH];
      out_last  <= bus.s_tlast[gnt_idx];
      out_dest  <= bus.s_tdest[gnt_idx*TDEST_WIDTH +: TDEST_WIDTH];
      out_user  <= bus.s_tuser[gnt_idx*TUSER_WIDTH +: TUSER_WIDTH];
      out_id    <= gnt_idx;
    end else if (bus.m_tready) begin
      // fields keep their value; only valid is withdrawn once consumed
      out_valid <= 1'b0;
    end
  end

  // one-hot view of the grant, empty while arbitrating
  always_comb begin
    grant_vec = '0;
    if (state == PASS) begin
      grant_vec[gnt_idx] = 1'b1;
    end
  end

  assign bus.s_tready = ready;
  assign bus.m_tvalid = out_valid;
  assign bus.m_tdata  = out_data;
  assign bus.m_tkeep  = out_keep;
  assign bus.m_tlast  = out_last;
  assign bus.m_tdest  = out_dest;
  assign bus.m_tuser  = out_user;
  assign bus.m_tid    = out_id;
  assign bus.grant    = grant_vec;
  assign bus.busy     = (state == PASS);

endmodule

// File: tb/tb_axi_stream_rr_arbiter.sv
// Directed bench for the stream arbiter: cycle table for arbitration order, hand sequences for stalls, drops and reset.
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpressure: m_tready held high in the table, toggled in the stall sequence.
module tb_axi_stream_rr_arbiter;
  localparam int NP = 4;
  localparam int DW = 16;
  localparam int KW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  axi_stream_rr_arbiter_if #(
    .NUM_PORTS(NP), .TDATA_WIDTH(DW), .TDEST_WIDTH(1), .TUSER_WIDTH(1), .IDX_WIDTH(2)
  ) bus ();

  axi_stream_rr_arbiter #(
    .NUM_PORTS(NP), .TDATA_WIDTH(DW), .TDEST_WIDTH(1), .TUSER_WIDTH(1), .IDX_WIDTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // per-port payload; sideband fields are a fixed function of the port number
  logic [DW-1:0] pdat [NP];
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      bus.s_tdata[i*DW +: DW] = pdat[i];
      bus.s_tkeep[i*KW +: KW] = KW'(i);
      bus.s_tdest[i]          = i[0];
      bus.s_tuser[i]          = i[1];
    end
  end

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [3:0]  last;
    logic [63:0] dat;
    logic [3:0]  gnt;   // expected grant; equals s_tready with m_tready high
    logic        busy;
    logic        mvld;
    logic [15:0] mdat;
    logic        mlast;
    logic [1:0]  tid;
  } vec_t;

  vec_t        vecs[$];
  int          total = 0;
  int          bad   = 0;
  int          rot[5];
  int          b, rx, gap;
  logic        done, mr, hold;
  logic [63:0] cdat;

  function automatic logic [63:0] at(input int p, input logic [15:0] v);
    logic [63:0] r;
    r = '0;
    r[p*16 +: 16] = v;
    return r;
  endfunction

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] l,
                              input logic [63:0] d, input logic [3:0] g, input logic bz,
                              input logic mv, input logic [15:0] md, input logic ml,
                              input logic [1:0] t);
    vec_t x;
    x.rst = r;  x.vld = v;   x.last = l;  x.dat = d;   x.gnt = g;
    x.busy = bz; x.mvld = mv; x.mdat = md; x.mlast = ml; x.tid = t;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [63:0] d);
    bus.s_tvalid = v;
    bus.s_tlast  = l;
    for (int i = 0; i < NP; i++) pdat[i] = d[i*16 +: 16];
  endtask

  task automatic chk_reset(input string name);
    chk(name, {bus.m_tvalid, bus.m_tdata, bus.m_tkeep, bus.m_tlast, bus.m_tdest,
               bus.m_tuser, bus.m_tid, bus.grant, bus.busy, bus.s_tready}, 64'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(4'b0000, 4'b0000, 64'h0);
    bus.m_tready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.m_tready = 1'b1;
    drive(4'b0000, 4'b0000, 64'h0);
`ifdef AXIS_ARB_STRICT_PRIO_EN
    rot = '{0, 0, 0, 0, 0};
`else
    rot = '{0, 1, 3, 0, 1};
`endif

    // port 1, 3-beat frame; then reset
    vecs.push_back(mk(0, 4'b0010, 4'b0000, at(1, 16'hA1), 4'b0000, 0, 0, 16'h0,  0, 0));
    vecs.push_back(mk(0, 4'b0010, 4'b0000, at(1, 16'hA1), 4'b0010, 1, 0, 16'h0,  0, 0));
    vecs.push_back(mk(0, 4'b0010, 4'b0000, at(1, 16'hA2), 4'b0010, 1, 1, 16'hA1, 0, 1));
    vecs.push_back(mk(0, 4'b0010, 4'b0010, at(1, 16'hA3), 4'b0010, 1, 1, 16'hA2, 0, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 64'h0,         4'b0000, 0, 1, 16'hA3, 1, 1));
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 64'h0,         4'b0000, 0, 0, 16'h0,  0, 0));
    // ports 0 and 2 with 2-beat frames from reset: port 0 first, no interleave
    vecs.push_back(mk(0, 4'b0101, 4'b0000, at(0, 16'h10) | at(2, 16'h20), 4'b0000, 0, 0, 16'h0,  0, 0));
    vecs.push_back(mk(0, 4'b0101, 4'b0000, at(0, 16'h10) | at(2, 16'h20), 4'b0001, 1, 0, 16'h0,  0, 0));
    vecs.push_back(mk(0, 4'b0101, 4'b0001, at(0, 16'h11) | at(2, 16'h20), 4'b0001, 1, 1, 16'h10, 0, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, at(2, 16'h20),                 4'b0000, 0, 1, 16'h11, 1, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, at(2, 16'h20),                 4'b0100, 1, 0, 16'h0,  0, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, at(2, 16'h21),                 4'b0100, 1, 1, 16'h20, 0, 2));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 64'h0,                         4'b0000, 0, 1, 16'h21, 1, 2));
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 64'h0,                         4'b0000, 0, 0, 16'h0,  0, 0));
    // ports 0, 1, 3 with back-to-back 1-beat frames
    cdat = at(0, 16'h30) | at(1, 16'h31) | at(3, 16'h33);
    vecs.push_back(mk(0, 4'b1011, 4'b1011, cdat, 4'b0000, 0, 0, 16'h0, 0, 0));
    for (int j = 0; j < 5; j++) begin
      vecs.push_back(mk(0, 4'b1011, 4'b1011, cdat, 4'(1 << rot[j]), 1, 0, 16'h0, 0, 0));
      vecs.push_back(mk(0, (j == 4) ? 4'b0000 : 4'b1011, 4'b1011, cdat, 4'b0000, 0, 1,
                        16'(16'h30 + rot[j]), 1, 2'(rot[j])));
    end
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 64'h0, 4'b0000, 0, 0, 16'h0, 0, 0));

    repeat (3) @(negedge clk);
    #1;
    chk_reset("reset_state");

    foreach (vecs[n]) begin
      @(negedge clk);
      rst = vecs[n].rst;
      drive(vecs[n].vld, vecs[n].last, vecs[n].dat);
      bus.m_tready = 1'b1;
      #1;
      chk($sformatf("row%0d_grant", n), bus.grant, vecs[n].gnt);
      chk($sformatf("row%0d_s_tready", n), bus.s_tready, vecs[n].gnt);
      chk($sformatf("row%0d_busy", n), bus.busy, vecs[n].busy);
      chk($sformatf("row%0d_m_tvalid", n), bus.m_tvalid, vecs[n].mvld);
      if (vecs[n].mvld) begin
        chk($sformatf("row%0d_m_tdata", n), bus.m_tdata, vecs[n].mdat);
        chk($sformatf("row%0d_m_tlast", n), bus.m_tlast, vecs[n].mlast);
        chk($sformatf("row%0d_m_tid", n), bus.m_tid, vecs[n].tid);
        chk($sformatf("row%0d_sideband", n), {bus.m_tkeep, bus.m_tdest, bus.m_tuser},
            {KW'(vecs[n].tid), vecs[n].tid[0], vecs[n].tid[1]});
      end
    end

    // m_tready toggling during a 4-beat frame on port 1
    do_reset();
    b = 0; rx = 0; mr = 1'b0;
    for (int cyc = 0; cyc < 40 && rx < 4; cyc++) begin
      @(negedge clk);
      mr = ~mr;
      bus.m_tready = mr;
      drive((b < 4) ? 4'b0010 : 4'b0000, (b == 3) ? 4'b0010 : 4'b0000, at(1, 16'(16'h40 + b)));
      #1;
      if (bus.m_tvalid && !bus.m_tready) chk("stall_s_tready", bus.s_tready, 4'b0000);
      if (bus.m_tvalid) begin
        chk("stall_m_tdata", bus.m_tdata, 16'(16'h40 + rx));
        chk("stall_m_tlast", bus.m_tlast, (rx == 3));
        chk("stall_m_tid", bus.m_tid, 2'd1);
        if (bus.m_tready) rx++;
      end
      if (bus.s_tvalid[1] && bus.s_tready[1]) b++;
    end
    chk("stall_beats", rx, 4);

    // port 2 drops valid mid-frame while port 0 waits
    do_reset();
    b = 0; gap = 0; rx = 0; done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      bus.m_tready = 1'b1;
      hold = (b == 2) && (gap < 3);
      if (hold) gap++;
      drive({1'b0, ~hold, 1'b0, (cyc > 0)}, {1'b0, (b == 3), 1'b0, 1'b1},
            at(2, 16'(16'h50 + b)) | at(0, 16'h60));
      #1;
      if (cyc > 0) chk("drop_grant_held", bus.grant, 4'b0100);
      if (bus.m_tvalid) begin
        chk("drop_m_tid", bus.m_tid, 2'd2);
        chk("drop_m_tdata", bus.m_tdata, 16'(16'h50 + rx));
        rx++;
      end
      if (bus.s_tvalid[2] && bus.s_tready[2]) begin
        if (b == 3) done = 1'b1;
        b++;
      end
    end
    chk("drop_frame_done", done, 1'b1);
    @(negedge clk);
    drive(4'b0001, 4'b0001, at(0, 16'h60));
    #1;
    chk("drop_gap_grant", bus.grant, 4'b0000);
    chk("drop_last_beat", {bus.m_tvalid, bus.m_tlast, bus.m_tid, bus.m_tdata}, {1'b1, 1'b1, 2'd2, 16'h53});
    @(negedge clk);
    #1;
    chk("drop_p0_grant", bus.grant, 4'b0001);
    @(negedge clk);
    drive(4'b0000, 4'b0000, 64'h0);
    #1;
    chk("drop_p0_beat", {bus.m_tvalid, bus.m_tid, bus.m_tdata}, {1'b1, 2'd0, 16'h60});

    // reset pulse during beat 2 of a 4-beat frame, then port 3 request
    do_reset();
    @(negedge clk);
    drive(4'b0001, 4'b0000, at(0, 16'h70));
    #1;
    chk("rst_idle_ready", bus.s_tready, 4'b0000);
    @(negedge clk);
    #1;
    chk("rst_beat1_ready", bus.s_tready, 4'b0001);
    @(negedge clk);
    drive(4'b0001, 4'b0000, at(0, 16'h71));
    rst = 1'b1;
    #1;
    chk("rst_beat1_out", {bus.m_tvalid, bus.m_tdata}, {1'b1, 16'h70});
    @(negedge clk);
    rst = 1'b0;
    drive(4'b1000, 4'b1000, at(3, 16'h80));
    #1;
    chk_reset("rst_mid_frame_state");
    @(negedge clk);
    #1;
    chk("rst_p3_grant", {bus.grant, bus.s_tready}, {4'b1000, 4'b1000});
    @(negedge clk);
    drive(4'b0000, 4'b0000, 64'h0);
    #1;
    chk("rst_p3_beat", {bus.m_tvalid, bus.m_tlast, bus.m_tid, bus.m_tdata},
        {1'b1, 1'b1, 2'd3, 16'h80});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_stream_rr_arbiter.md
# axi_stream_rr_arbiter

Packet-atomic N:1 AXI4-Stream arbiter for the TSN frame generator datapath. It merges NUM_PORTS frame sources onto one AXI4-Stream master. A grant is held from the first beat to the `tlast` beat, so frames never interleave. The output passes through a single registered pipeline stage, and the source index is tagged on `m_tid`.

## Interface
- NUM_PORTS, 4: number of slave inputs (2..16)
- TDATA_WIDTH, 64: data width in bits, multiple of 8
- TDEST_WIDTH, 1: tdest width
- TUSER_WIDTH, 1: tuser width
- IDX_WIDTH, $clog2(NUM_PORTS): grant index width; drives `m_tid` width
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- s_tvalid  in  NUM_PORTS  per-port valid
- s_tready  out  NUM_PORTS  per-port ready
- s_tdata  in  NUM_PORTS*TDATA_WIDTH  port i occupies bits [i*TDATA_WIDTH +: TDATA_WIDTH]
- s_tkeep  in  NUM_PORTS*TDATA_WIDTH/8  per-port byte keep, same packing
- s_tlast  in  NUM_PORTS  per-port end of frame
- s_tdest  in  NUM_PORTS*TDEST_WIDTH  per-port tdest
- s_tuser  in  NUM_PORTS*TUSER_WIDTH  per-port tuser
- m_tvalid  out  1  output valid
- m_tready  in  1  output ready
- m_tdata, m_tkeep, m_tlast, m_tdest, m_tuser  out  widths as per port  output beat
- m_tid  out  IDX_WIDTH  index of the source port of the current beat
- grant  out  NUM_PORTS  one-hot current grant, all zero in IDLE
- busy  out  1  high in PASS state

## Operation
- FSM with two states, IDLE and PASS. Register `gnt_idx` and round-robin pointer `rr_ptr` (the last served port).
- IDLE: if any `s_tvalid` is high, select the winner and latch it into `gnt_idx`, then go to PASS. All `s_tready` are 0 in IDLE.
- Round-robin selection: the first requesting port scanning `rr_ptr+1, rr_ptr+2, ...` modulo NUM_PORTS.
- PASS: `s_tready[gnt_idx] = ~m_tvalid | m_tready`. All other `s_tready` are 0. An accepted beat loads the output register.
- An accepted beat with `s_tlast` sets `rr_ptr <= gnt_idx` and returns the FSM to IDLE.
- Output register: loads on `s_tvalid[g] & s_tready[g]`. It clears `m_tvalid` on `m_tready` when no new load occurs. It drains independently of FSM state.
- Every output field, including `m_tid = gnt_idx`, is registered with the beat.
- A `s_tvalid` drop mid-frame on the granted port holds the grant; no other port is served.
- A port raising `s_tvalid` mid-frame waits for the frame to end.
- A zero-length frame cannot occur: each frame has at least one beat.

## Timing
- Reset values:
  - state IDLE
  - `rr_ptr` = NUM_PORTS-1, so port 0 wins first
  - `gnt_idx` = 0
  - `m_tvalid`, `m_tlast`, `m_tdata`, `m_tkeep`, `m_tdest`, `m_tuser`, `m_tid` = 0
  - `grant` = 0, `busy` = 0, `s_tready` = 0
- Reset asserted mid-frame: the output register and the in-flight beat are discarded. The next frame starts fresh in IDLE.
- Arbitration costs 1 cycle: request seen in IDLE at cycle t, first `s_tready` at t+1.
- Data latency: accept at cycle t, `m_tvalid` at t+1.
- Throughput inside a frame: 1 beat/cycle while `m_tready` = 1.
- Inter-frame gap on the slave side: 1 idle cycle.
- AXI rules:
  - `m_tvalid` is never withdrawn until `m_tready`.
  - Output fields are stable while `m_tvalid & ~m_tready`.
  - `s_tready` does not depend combinationally on `s_tvalid`.

## Configuration
- `AXIS_ARB_STRICT_PRIO_EN` defined: fixed priority, lowest requesting index wins in IDLE. `rr_ptr` is not updated and has no functional effect.
- `AXIS_ARB_STRICT_PRIO_EN` undefined (default): round-robin as above.
- Frame atomicity, latency and reset behaviour are identical in both builds.

## Test plan
- Port 1 sends a 3-beat frame (0xA1, 0xA2, 0xA3 with tlast), `m_tready` = 1:
  - m side shows 3 consecutive beats, the first 2 cycles after first `s_tvalid`, with `m_tid` = 1.
  - `tlast` only on 0xA3; `busy` falls the cycle after the tlast accept.
- Ports 0 and 2 both request 2-beat frames from reset: output order is port 0 frame, then port 2 frame, never interleaved.
- Ports 0, 1 and 3 each send 1-beat frames continuously: rotation on `m_tid` is 0, 1, 3, 0, 1, 3…
  - With `AXIS_ARB_STRICT_PRIO_EN`: always 0 while port 0 requests.
- `m_tready` toggles 1/0 every cycle during a 4-beat frame:
  - no beat lost or duplicated;
  - fields stable while stalled;
  - `s_tready` low whenever `m_tvalid & ~m_tready`.
- Port 2 drops `s_tvalid` for 3 cycles mid-frame while port 0 requests: port 0 gets no grant until port 2 tlast is accepted.
- `rst` pulsed for 1 cycle during beat 2 of a 4-beat frame:
  - next cycle all outputs are at reset values.
  - a new request on port 3 is granted with the normal 1-cycle arbitration.
